// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage : instruction-fetch stage of the 5-stage MIPS pipeline.
//
// Owns the word-addressed fetch PC, talks to instruction memory over a
// req/ack handshake and drives the IF/ID register (pc, inst) read by
// id_stage. Redirects from ID (jr > j > br) kill the wrong-path fetch; the
// hazard unit's stall freezes IF/ID and the fetch PC. A bubble is inst = 0.
//
// Ports
//   clk, reset_          : clock, synchronous active-low reset
//   stall                : hold IF/ID and the fetch PC
//   br, j, jr            : redirect requests from ID
//   addr_br/j/jr [31:0]  : redirect targets (word addresses)
//   imem_req             : fetch request valid
//   imem_addr [31:0]     : fetch word address
//   imem_ack             : imem_rdata valid, completes the request
//   imem_rdata [31:0]    : fetched instruction
//   pc, inst [31:0]      : IF/ID register
//   fetch_wait           : request outstanding and not yet acknowledged
// ---------------------------------------------------------------------------
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_,
    input  logic        stall,
    input  logic        br,
    input  logic        j,
    input  logic        jr,
    input  logic [31:0] addr_br,
    input  logic [31:0] addr_j,
    input  logic [31:0] addr_jr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] inst,
    output logic        fetch_wait
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DROP  = 2'd3
    } state_e;

    state_e      r_state;
    state_e      w_nextState;

    logic [31:0] r_fpc;
    logic [31:0] r_dropAddr;
    logic [31:0] r_holdInst;
    logic [31:0] r_holdPc;
    logic [31:0] r_pc;
    logic [31:0] r_inst;

    logic        w_redir;
    logic [31:0] w_target;

    // A stalled ID stage cannot own a valid branch decision, so stall masks
    // every redirect.
    assign w_redir  = !stall && (br || j || jr);
    assign w_target = jr ? addr_jr : (j ? addr_j : addr_br);

    assign pc   = r_pc;
    assign inst = r_inst;

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic. A redirect without ack leaves a request in flight
    // that must not be withdrawn, so it is parked in DROP until the ack.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: w_nextState = FETCH;
            FETCH: begin
                if (w_redir) begin
                    w_nextState = imem_ack ? FETCH : DROP;
                end else if (stall && imem_ack) begin
                    w_nextState = HOLD;
                end
            end
            HOLD: begin
                if (!stall) begin
                    w_nextState = FETCH;
                end
            end
            DROP: begin
                if (imem_ack) begin
                    w_nextState = FETCH;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Memory-side outputs. DROP keeps presenting the abandoned address so the
    // request stays stable until memory acknowledges it.
    always_comb begin
        imem_req   = 1'b0;
        imem_addr  = r_fpc;
        fetch_wait = 1'b0;
        case (r_state)
            FETCH: begin
                imem_req   = 1'b1;
                fetch_wait = !imem_ack;
            end
            DROP: begin
                imem_req   = 1'b1;
                imem_addr  = r_dropAddr;
                fetch_wait = !imem_ack;
            end
            default: begin
                imem_req   = 1'b0;
            end
        endcase
    end

    // Fetch PC, skid buffer and IF/ID register. An instruction returned while
    // stalled goes into the skid buffer and issues on the edge stall drops,
    // so nothing is lost or duplicated.
    always_ff @(posedge clk) begin
        if (!reset_) begin
            r_fpc      <= RESET_PC;
            r_dropAddr <= RESET_PC;
            r_holdInst <= '0;
            r_holdPc   <= RESET_PC;
            r_pc       <= RESET_PC;
            r_inst     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_inst <= '0;
                end
                FETCH: begin
                    if (w_redir) begin
                        r_fpc  <= w_target;
                        r_inst <= '0;
                        if (!imem_ack) begin
                            r_dropAddr <= r_fpc;
                        end
                    end else if (stall) begin
                        if (imem_ack) begin
                            r_holdInst <= imem_rdata;
                            r_holdPc   <= r_fpc;
                        end
                    end else if (imem_ack) begin
                        r_pc   <= r_fpc;
                        r_inst <= imem_rdata;
                        r_fpc  <= r_fpc + 32'd1;
                    end else begin
                        r_inst <= '0;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        if (w_redir) begin
                            r_fpc  <= w_target;
                            r_inst <= '0;
                        end else begin
                            r_pc   <= r_holdPc;
                            r_inst <= r_holdInst;
                            r_fpc  <= r_fpc + 32'd1;
                        end
                    end
                end
                DROP: begin
                    if (w_redir) begin
                        r_fpc <= w_target;
                    end
                    if (!stall) begin
                        r_inst <= '0;
                    end
                end
                default: begin
                    r_inst <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// ---------------------------------------------------------------------------
// tb_if_stage : scoreboard bench for if_stage.
//
// The reference model is the architectural instruction stream: a queue of
// PCs that must issue into IF/ID in order, restarted at the target on every
// accepted redirect and at RESET_PC on reset. A memory model answers
// requests with a chosen number of wait states and returns addr + DATA_OFS.
// A separate monitor pops the queue whenever IF/ID takes a new instruction.
// ---------------------------------------------------------------------------
module tb_if_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0100;
    localparam logic [31:0] DATA_OFS = 32'h2000_0000;

    logic        clk = 1'b0;
    logic        reset_;
    logic        stall;
    logic        br;
    logic        j;
    logic        jr;
    logic [31:0] addr_br;
    logic [31:0] addr_j;
    logic [31:0] addr_jr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        fetch_wait;

    int          assertCount = 0;
    int          failCount   = 0;

    logic [31:0] expQ[$];
    logic [31:0] nextPush;
    int          issued       = 0;
    bit          started      = 1'b0;
    logic [31:0] lastPc;
    logic [31:0] lastInst;

    bit          memInFlight  = 1'b0;
    int          memRemain    = 0;
    logic [31:0] memAddr;
    int unsigned waitMin      = 0;
    int unsigned waitMax      = 0;
    int          fetchWaitHigh = 0;

    if_stage #(.RESET_PC(RESET_PC)) dut (
        .clk        (clk),
        .reset_     (reset_),
        .stall      (stall),
        .br         (br),
        .j          (j),
        .jr         (jr),
        .addr_br    (addr_br),
        .addr_j     (addr_j),
        .addr_jr    (addr_jr),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .pc         (pc),
        .inst       (inst),
        .fetch_wait (fetch_wait)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Memory model: one request at a time, a random wait count per request,
    // and any request in flight is forgotten once reset has hit the DUT.
    task automatic memoryStep();
        if (reset_ == 1'b0) begin
            memInFlight = 1'b0;
            imem_ack    = 1'b0;
        end else begin
            if (memInFlight) begin
                checkOutput("req_held", 32'(imem_req), 32'd1);
                checkOutput("addr_stable", imem_addr, memAddr);
            end
            if (imem_req) begin
                if (!memInFlight) begin
                    memInFlight = 1'b1;
                    memAddr     = imem_addr;
                    memRemain   = int'($urandom_range(waitMax, waitMin));
                end
                if (memRemain == 0) begin
                    imem_ack    = 1'b1;
                    imem_rdata  = memAddr + DATA_OFS;
                    memInFlight = 1'b0;
                end else begin
                    imem_ack   = 1'b0;
                    imem_rdata = $urandom;
                    memRemain--;
                end
            end else begin
                imem_ack = 1'b0;
            end
        end
    endtask

    // One clock of stimulus: memory answers, inputs are driven, the expected
    // stream is updated, then the edge is taken.
    task automatic applyStimulus(input bit rstN, input bit st, input bit b,
                                 input bit jj, input bit jjr,
                                 input logic [31:0] ab, input logic [31:0] aj,
                                 input logic [31:0] ajr);
        bit inIdle;
        @(negedge clk);
        memoryStep();
        #1;
        checkOutput("fetch_wait", 32'(fetch_wait), 32'(memInFlight));
        if (memInFlight) fetchWaitHigh++;
        inIdle  = (reset_ == 1'b0);
        reset_  = rstN;
        stall   = st;
        br      = b;
        j       = jj;
        jr      = jjr;
        addr_br = ab;
        addr_j  = aj;
        addr_jr = ajr;
        if (!rstN) begin
            expQ.delete();
            nextPush = RESET_PC;
        end else if (!inIdle && !st && (b || jj || jjr)) begin
            expQ.delete();
            nextPush = jjr ? ajr : (jj ? aj : ab);
        end
        while (expQ.size() < 4) begin
            expQ.push_back(nextPush);
            nextPush = nextPush + 32'd1;
        end
        @(posedge clk);
        #2;
    endtask

    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        end
    endtask

    task automatic checkResetState();
        checkOutput("rst_pc", pc, RESET_PC);
        checkOutput("rst_inst", inst, 32'h0);
        checkOutput("rst_req", 32'(imem_req), 32'd0);
        checkOutput("rst_fetch_wait", 32'(fetch_wait), 32'd0);
    endtask

    // Monitor: on every non-reset edge, a stalled edge must leave IF/ID
    // untouched, otherwise a non-zero inst is the next instruction in order.
    initial begin
        logic [31:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (started && reset_ === 1'b1) begin
                if (stall) begin
                    checkOutput("frozen_pc", pc, lastPc);
                    checkOutput("frozen_inst", inst, lastInst);
                end else if (inst != 32'h0) begin
                    checkOutput("issue_expected", 32'(expQ.size() != 0), 32'd1);
                    if (expQ.size() != 0) begin
                        e = expQ.pop_front();
                        checkOutput("issue_pc", pc, e);
                        checkOutput("issue_inst", inst, e + DATA_OFS);
                        issued++;
                    end
                end
            end
            lastPc   = pc;
            lastInst = inst;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL timeout: got no end of test, expected end of test");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [31:0] oldA;
        int          b0;
        int          fw0;
        bit          rRst;
        bit          rSt;
        bit          rB;
        bit          rJ;
        bit          rJr;

        reset_     = 1'b0;
        stall      = 1'b0;
        br         = 1'b0;
        j          = 1'b0;
        jr         = 1'b0;
        addr_br    = '0;
        addr_j     = '0;
        addr_jr    = '0;
        imem_ack   = 1'b0;
        imem_rdata = '0;
        nextPush   = RESET_PC;
        expQ.delete();
        repeat (2) @(posedge clk);
        #2;
        started = 1'b1;
        checkResetState();

        // Release reset: first request appears in the following cycle.
        runCycles(1);
        checkOutput("start_req", 32'(imem_req), 32'd1);

        // Zero-wait memory: one instruction per cycle, consecutive addresses.
        for (int i = 0; i < 3; i++) begin
            checkOutput("seq_addr", imem_addr, RESET_PC + 32'(i));
            runCycles(1);
        end
        checkOutput("seq_pc", pc, 32'h0000_0102);
        checkOutput("seq_inst", inst, 32'h2000_0102);
        b0 = issued;
        runCycles(10);
        checkOutput("no_bubbles", 32'(issued - b0), 32'd10);

        // Two wait states: two bubbles then the instruction, per fetch.
        waitMin = 2;
        waitMax = 2;
        b0  = issued;
        fw0 = fetchWaitHigh;
        for (int k = 0; k < 3; k++) begin
            runCycles(1);
            checkOutput("ws_bubble1", inst, 32'h0);
            runCycles(1);
            checkOutput("ws_bubble2", inst, 32'h0);
            runCycles(1);
            checkOutput("ws_valid", 32'(inst != 32'h0), 32'd1);
        end
        checkOutput("ws_issued", 32'(issued - b0), 32'd3);
        checkOutput("ws_fetch_wait_cycles", 32'(fetchWaitHigh - fw0), 32'd6);

        // jr to 0x40 while the ack is still pending.
        oldA = expQ[0];
        runCycles(1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, '0, '0, 32'h40);
        checkOutput("drop_inst", inst, 32'h0);
        checkOutput("drop_req", 32'(imem_req), 32'd1);
        checkOutput("drop_addr", imem_addr, oldA);
        runCycles(1);
        checkOutput("drop_done_inst", inst, 32'h0);
        checkOutput("jr_target_addr", imem_addr, 32'h40);
        runCycles(2);
        checkOutput("jr_wait_inst", inst, 32'h0);
        runCycles(1);
        checkOutput("jr_pc", pc, 32'h40);
        checkOutput("jr_inst", inst, 32'h2000_0040);

        // Stall for three cycles coincident with the ack of 0x105.
        waitMin = 0;
        waitMax = 0;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0, 32'h105, '0);
        checkOutput("j_bubble", inst, 32'h0);
        checkOutput("j_addr", imem_addr, 32'h105);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
            checkOutput("hold_req", 32'(imem_req), 32'd0);
            checkOutput("hold_inst", inst, 32'h0);
        end
        runCycles(1);
        checkOutput("unstall_pc", pc, 32'h105);
        checkOutput("unstall_inst", inst, 32'h2000_0105);
        runCycles(1);
        checkOutput("after_pc", pc, 32'h106);

        // br together with jr: jr target wins.
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h500, '0, 32'h700);
        checkOutput("prio_addr", imem_addr, 32'h700);
        runCycles(3);
        checkOutput("prio_pc", pc, 32'h702);

        // br during stall is ignored.
        oldA = expQ[0];
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h500, '0, '0);
        checkOutput("stall_br_req", 32'(imem_req), 32'd0);
        runCycles(1);
        checkOutput("stall_br_pc", pc, oldA);
        checkOutput("stall_br_addr", imem_addr, oldA + 32'd1);

        // Fetch PC wraps from 0xFFFF_FFFF to 0.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0, 32'hFFFF_FFFE, '0);
        runCycles(2);
        checkOutput("wrap_pc", pc, 32'hFFFF_FFFF);
        checkOutput("wrap_addr", imem_addr, 32'h0);
        runCycles(1);
        checkOutput("wrap_pc0", pc, 32'h0);

        // Reset while parked in DROP.
        waitMin = 3;
        waitMax = 3;
        oldA = expQ[0];
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, '0, '0, 32'h300);
        checkOutput("mid_drop_req", 32'(imem_req), 32'd1);
        checkOutput("mid_drop_addr", imem_addr, oldA);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        checkResetState();
        runCycles(1);
        checkOutput("restart_req", 32'(imem_req), 32'd1);
        checkOutput("restart_addr", imem_addr, RESET_PC);

        // Randomized traffic against the stream model.
        waitMin = 0;
        waitMax = 2;
        b0 = issued;
        for (int k = 0; k < 800; k++) begin
            rRst = ($urandom_range(99, 0) != 0);
            rSt  = ($urandom_range(4, 0) == 0);
            rB   = ($urandom_range(19, 0) == 0);
            rJ   = ($urandom_range(19, 0) == 0);
            rJr  = ($urandom_range(19, 0) == 0);
            applyStimulus(rRst, rSt, rB, rJ, rJr,
                          $urandom & 32'h0000_FFFF, $urandom & 32'h0000_FFFF,
                          $urandom & 32'h0000_FFFF);
        end
        checkOutput("random_progress", 32'((issued - b0) > 50), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the 5-stage MIPS pipeline: owns the word-addressed fetch PC, issues requests to instruction memory over a req/ack handshake, and drives the IF/ID pipeline register (`pc`, `inst`) that `id_stage` decodes. It consumes the `br`/`j`/`jr` redirects and targets produced in ID, flushes the wrong-path fetch, and honours the hazard unit's `stall`. Bubbles are encoded as `inst = 32'h0`, which ID treats as a nop.

## Interface

Parameters:
- `RESET_PC`, default `32'h0000_0000`: fetch address after reset. Word address.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `reset_` in 1: reset, synchronous, active-low.
- `stall` in 1: hazard unit holds the IF/ID register and the fetch PC.
- `br`, `j`, `jr` in 1 each: redirect requests from ID.
- `addr_br`, `addr_j`, `addr_jr` in 32 each: redirect targets, word addresses.
- `imem_req` out 1: fetch request valid.
- `imem_addr` out 32: fetch word address.
- `imem_ack` in 1: `imem_rdata` valid this cycle; completes the request.
- `imem_rdata` in 32: fetched instruction.
- `pc` out 32: IF/ID PC of `inst`.
- `inst` out 32: IF/ID instruction; `0` means bubble.
- `fetch_wait` out 1: high in FETCH or DROP while `imem_ack` is low.

## Operation

Registers:
- `fpc`: next fetch address.
- `drop_addr`: address of the abandoned request.
- `hold_inst` and `hold_pc`: skid buffer.
- `state`: one of IDLE, FETCH, HOLD, DROP.

Redirect:
- `redir = !stall && (br || j || jr)`.
- Target priority: `jr` > `j` > `br`.
- When `stall` is high, redirect inputs are ignored.

Outputs:
- In FETCH, `imem_req = 1` and `imem_addr = fpc`.
- In DROP, `imem_req = 1` and `imem_addr = drop_addr`.
- Otherwise `imem_req = 0` and `imem_addr = fpc`.
- Once raised, `imem_req` and `imem_addr` stay stable until the `imem_ack` cycle. Requests are never withdrawn, except by reset.

IDLE:
- Next state is FETCH unconditionally.
- IF/ID holds a bubble.

FETCH, evaluated in this order:
- `redir`: `fpc` <= target, `inst` <= 0.
  - If `imem_ack`: data discarded, stay in FETCH.
  - If no `imem_ack`: `drop_addr` <= `fpc`, go to DROP.
- `stall` with `imem_ack`: `hold_inst` <= `imem_rdata`, `hold_pc` <= `fpc`. IF/ID unchanged. Go to HOLD.
- `stall` without `imem_ack`: no change.
- `imem_ack`: `pc` <= `fpc`, `inst` <= `imem_rdata`, `fpc` <= `fpc + 1`.
- Otherwise: `inst` <= 0 and `pc` unchanged, i.e. a bubble.

HOLD (no request outstanding):
- `stall`: no change.
- `redir`: buffer discarded, `fpc` <= target, `inst` <= 0, go to FETCH.
- Otherwise: `pc` <= `hold_pc`, `inst` <= `hold_inst`, `fpc` <= `fpc + 1`, go to FETCH.

DROP (waiting for the wrong-path ack):
- `redir`: `fpc` <= new target (latest redirect wins).
- Unless `stall`, `inst` <= 0.
- On `imem_ack`: data discarded, go to FETCH.

Arithmetic:
- `fpc + 1` is modulo 2^32. `32'hFFFF_FFFF` wraps to `0`.

## Timing

Reset (synchronous, `reset_ = 0` at an edge):
- `state` = IDLE, `fpc` = `RESET_PC`.
- `pc` = `RESET_PC`, `inst` = 0.
- `imem_req` = 0, `fetch_wait` = 0.
- Hold buffer invalid.
- A request in flight is abandoned; instruction memory must drop it on reset.

Start-up:
- First `imem_req` is asserted in the cycle after reset is released.

Latency and throughput:
- Ack in cycle N gives `inst` valid in cycle N+1.
- Zero-wait memory (ack in the same cycle as req) sustains 1 instruction per cycle.

Redirects:
- A redirect in cycle N gives a bubble in N+1 and a target request in N+1 when no request is outstanding. That is 1 bubble total.
- There are no delay slots.

Simultaneous events:
- `stall` with redirect: `stall` wins and the redirect is ignored.
- Redirect with ack: the redirect wins and the data is dropped.
- `stall` falling while in HOLD: the buffered instruction issues that same edge, so no instruction is lost or duplicated.

## Test plan

- Reset, `RESET_PC = 32'h100`, zero-wait memory returning `rdata = addr + 32'h2000_0000`:
  - `imem_addr` = 100, 101, 102 on consecutive cycles.
  - `inst` = 2000_0100, 2000_0101, … one cycle later.
  - No bubbles.
- Memory with 2 wait states:
  - `fetch_wait` is high for 2 cycles per fetch.
  - `inst` = 0 for 2 cycles, then the instruction.
  - `imem_addr` is stable throughout.
- `jr` to `32'h40` while ack is pending:
  - DROP holds the old address until ack.
  - The old data never reaches `inst`.
  - The next request goes to `32'h40`.
  - Throughout, `inst` = 0 until the `32'h40` instruction arrives.
- `stall` high for 3 cycles, coincident with ack of PC `32'h105`:
  - `pc`/`inst` are frozen.
  - `imem_req` = 0 in HOLD.
  - On release, PC `32'h105` issues once, then `32'h106`.
- Corner cases:
  - `br` and `jr` asserted together: the `addr_jr` target is taken.
  - `br` with `stall` = 1: ignored.
  - `fpc = 32'hFFFF_FFFF`: next fetch is `32'h0`.
  - `reset_ = 0` mid-DROP: all outputs return to reset values on the next edge.
